// File: rtl/platform_nios_mult_pipe.sv
// platform_nios_mult_pipe: stallable Nios-style multiplier built from 16x16 partial products.
// PLATFORM_NIOS_MULT_HI_EN builds the full 2*DATA_W product for the MULX modes; otherwise only the low word exists.
module platform_nios_mult_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] mul_src1,
  input  logic [DATA_W-1:0] mul_src2,
  input  logic [1:0]        mul_mode,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] mul_result,
  output logic              busy
);
`ifdef PLATFORM_NIOS_MULT_HI_EN
  localparam int PW = 2 * DATA_W;
`else
  localparam int PW = DATA_W;
`endif
  localparam int NL = DATA_W / 16;
  localparam int NR = NL + 1;
  localparam int ND = (PIPE_STAGES > 2) ? PIPE_STAGES - 2 : 1;
  typedef logic [NR-1:0][PW-1:0] rows_t;
  function automatic logic [PW-1:0] add_rows(input rows_t r);
    logic [PW-1:0] s;
    s = '0;
    for (int k = 0; k < NR; k++) s = s + r[k];
    return s;
  endfunction
  // In the low-only build both slices are the same word, so every mode acts as MUL.
  function automatic logic [DATA_W-1:0] pick(input logic [PW-1:0] p, input logic [1:0] m);
    return (m == 2'b00) ? p[DATA_W-1:0] : p[PW-1 -: DATA_W];
  endfunction
  rows_t             in_row;
  logic [PW-1:0]     h_p, t_p;
  logic [1:0]        h_md, t_md;
  logic              h_v, t_v, row_v, dly_v;
`ifdef PLATFORM_NIOS_MULT_HI_EN
  // Two's-complement fixup: a signed operand with its msb set subtracts the other operand at weight 2^DATA_W.
  logic [PW-1:0] corr;
  assign corr = ((mul_mode[1] & mul_src1[DATA_W-1]) ? {mul_src2, {DATA_W{1'b0}}} : '0)
              + ((&mul_mode & mul_src2[DATA_W-1]) ? {mul_src1, {DATA_W{1'b0}}} : '0);
`endif
  always_comb begin
    in_row = '0;
    for (int i = 0; i < NL; i++)
      for (int j = 0; j < NL; j++)
        in_row[i] = in_row[i] + ((PW'(mul_src1[16*i +: 16]) * PW'(mul_src2[16*j +: 16])) << (16 * (i + j)));
`ifdef PLATFORM_NIOS_MULT_HI_EN
    in_row[NR-1] = -corr;
`endif
  end
  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign h_p   = add_rows(in_row);
      assign h_md  = mul_mode;
      assign h_v   = in_valid;
      assign row_v = 1'b0;
    end else begin : g_rows
      rows_t      r_row;
      logic [1:0] r_md;
      logic       r_v;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_row <= '0;
          r_md  <= '0;
          r_v   <= 1'b0;
        end else if (!stall) begin
          r_row <= in_row;
          r_md  <= mul_mode;
          r_v   <= in_valid;
        end
      end
      assign h_p   = add_rows(r_row);
      assign h_md  = r_md;
      assign h_v   = r_v;
      assign row_v = r_v;
    end
    if (PIPE_STAGES > 2) begin : g_delay
      logic [ND-1:0][PW-1:0] d_p;
      logic [ND-1:0][1:0]    d_md;
      logic [ND-1:0]         d_v;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          d_p  <= '0;
          d_md <= '0;
          d_v  <= '0;
        end else if (!stall) begin
          d_p[0]  <= h_p;
          d_md[0] <= h_md;
          d_v[0]  <= h_v;
          for (int k = 1; k < ND; k++) begin
            d_p[k]  <= d_p[k-1];
            d_md[k] <= d_md[k-1];
            d_v[k]  <= d_v[k-1];
          end
        end
      end
      assign t_p   = d_p[ND-1];
      assign t_md  = d_md[ND-1];
      assign t_v   = d_v[ND-1];
      assign dly_v = |d_v;
    end else begin : g_nodelay
      assign t_p   = h_p;
      assign t_md  = h_md;
      assign t_v   = h_v;
      assign dly_v = 1'b0;
    end
  endgenerate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      mul_result <= '0;
    end else if (!stall) begin
      out_valid <= t_v;
      if (t_v) mul_result <= pick(t_p, t_md);
    end
  end
  assign busy = out_valid | row_v | dly_v;
endmodule

// File: tb/tb_platform_nios_mult_pipe.sv
// tb_platform_nios_mult_pipe: random and directed checks against a latency-queue reference model.
module tb_platform_nios_mult_pipe;
  localparam int P = 2;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] mul_src1 = '0;
  logic [31:0] mul_src2 = '0;
  logic [1:0]  mul_mode = '0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] mul_result;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  int          rq[$];
  logic [31:0] vq[$];
  logic [31:0] got_q[$];
  logic        exp_ov = 1'b0;
  logic [31:0] exp_res = '0;

  platform_nios_mult_pipe #(.DATA_W(32), .PIPE_STAGES(P)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .mul_src1(mul_src1),
    .mul_src2(mul_src2), .mul_mode(mul_mode), .stall(stall),
    .out_valid(out_valid), .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
`ifdef PLATFORM_NIOS_MULT_HI_EN
    logic [63:0] ea, eb, p;
    ea = m[1] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (m == 2'b11) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (m == 2'b00) ? p[31:0] : p[63:32];
`else
    return a * b;
`endif
  endfunction

  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m, input logic st);
    in_valid = v; mul_src1 = a; mul_src2 = b; mul_mode = m; stall = st;
    @(posedge clk);
    if (!st) begin
      if (v) begin
        rq.push_back(P);
        vq.push_back(ref_res(a, b, m));
      end
      foreach (rq[k]) rq[k] = rq[k] - 1;
      exp_ov = 1'b0;
      if (rq.size() > 0 && rq[0] == 0) begin
        exp_ov  = 1'b1;
        exp_res = vq.pop_front();
        void'(rq.pop_front());
      end
    end
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("busy", 64'(busy), 64'(exp_ov || rq.size() > 0));
    chk("mul_result", 64'(mul_result), 64'(exp_res));
    if (out_valid && !st) got_q.push_back(mul_result);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic expect_got(input string tag, input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3, input int n);
    logic [31:0] e [4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int k = 0; k < n && k < got_q.size(); k++) chk(tag, 64'(got_q[k]), 64'(e[k]));
    got_q.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res", 64'(mul_result), 64'd0);
    reset_n = 1'b1;
    cyc(1'b1, 32'h0001_0000, 32'h0001_0000, 2'b00, 1'b0);
    cyc(1'b1, 32'h0001_0000, 32'h0001_0000, 2'b01, 1'b0);
    chk("s1_lat", 64'(out_valid), 64'd1);
    idle(3);
`ifdef PLATFORM_NIOS_MULT_HI_EN
    expect_got("single", 32'h0, 32'h1, 32'h0, 32'h0, 2);
`else
    expect_got("single", 32'h0, 32'h0, 32'h0, 32'h0, 2);
`endif
    for (int m = 0; m < 4; m++) cyc(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'(m), 1'b0);
    idle(3);
`ifdef PLATFORM_NIOS_MULT_HI_EN
    expect_got("ones", 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 4);
`else
    expect_got("ones", 32'h1, 32'h1, 32'h1, 32'h1, 4);
`endif
    cyc(1'b1, 32'd3, 32'd5, 2'b00, 1'b0);
    cyc(1'b1, 32'd7, 32'd9, 2'b00, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'hDEAD_BEEF, 32'h1234, 2'b11, 1'b1);
    cyc(1'b1, 32'h1234_5678, 32'h10, 2'b00, 1'b0);
    cyc(1'b1, 32'h8000_0000, 32'd2, 2'b11, 1'b0);
    idle(3);
`ifdef PLATFORM_NIOS_MULT_HI_EN
    expect_got("stream", 32'd15, 32'd63, 32'h2345_6780, 32'hFFFF_FFFF, 4);
`else
    expect_got("stream", 32'd15, 32'd63, 32'h2345_6780, 32'h0, 4);
`endif
    cyc(1'b1, 32'h0000_1234, 32'h0000_5678, 2'b00, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ov", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res", 64'(mul_result), 64'd0);
    rq.delete(); vq.delete(); got_q.delete();
    exp_ov = 1'b0; exp_res = '0;
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);
    expect_got("post_rst", 32'h0, 32'h0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      cyc(1'($urandom_range(0, 3) != 0), a, b, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
    end
    idle(4);
    chk("drain", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
